// File: rtl/vga_timing_if.sv
// Timing-controller bus: run/handshake controls in, raster position and strobes out.
interface vga_timing_if;
   logic       enable;
   logic       vblank_ack;
   logic       overrun_clr;
   logic [9:0] x;
   logic [9:0] y;
   logic       hsync;
   logic       vsync;
   logic       active;
   logic       pix_tick;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;
   logic       vblank_req;
   logic       overrun;

   modport master (
      input  enable, vblank_ack, overrun_clr,
      output x, y, hsync, vsync, active, pix_tick, line_start, frame_start,
             frame_count, vblank_req, overrun
   );

   modport slave (
      output enable, vblank_ack, overrun_clr,
      input  x, y, hsync, vsync, active, pix_tick, line_start, frame_start,
             frame_count, vblank_req, overrun
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel divider, x/y counters, sync/active decode,
// line/frame strobes and the vertical-blank update handshake.
//
// Handshake states:
//   state   | meaning
//   VB_IDLE | no update window open, vblank_ack ignored
//   VB_OPEN | window open (vblank_req=1), waiting for ack or first active line
module vga_timing_ctrl #(
   parameter int CLK_DIV  = 1,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACT    = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACT    = 480,
   parameter int V_FP     = 10,
   parameter bit SYNC_POL = 1'b0
) (
   input logic         clk,
   input logic         rst_n,
   vga_timing_if.master bus
);
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
         $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
      end
      if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_div_chk
         $error("vga_timing_ctrl: CLK_DIV must be 1..4");
      end
   endgenerate

   localparam logic [9:0] X_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_SYNC_END  = 10'(H_SYNC);
   localparam logic [9:0] Y_SYNC_END  = 10'(V_SYNC);
   localparam logic [9:0] X_ACT_FIRST = 10'(H_SYNC + H_BP);
   localparam logic [9:0] X_ACT_LAST  = 10'(H_SYNC + H_BP + H_ACT - 1);
   localparam logic [9:0] Y_ACT_FIRST = 10'(V_SYNC + V_BP);
   localparam logic [9:0] Y_ACT_LAST  = 10'(V_SYNC + V_BP + V_ACT - 1);
   localparam logic [9:0] Y_REQ       = 10'(V_SYNC + V_BP + V_ACT);
   localparam logic [1:0] DIV_LAST    = 2'(CLK_DIV - 1);

   typedef enum logic {VB_IDLE, VB_OPEN} vb_state_e;

   vb_state_e  state, state_nxt;
   logic [1:0] div;
   logic       tick, line_evt, frame_evt;
   logic [9:0] x_nxt, y_nxt;
   logic       req_rise, deadline, ovr_set;

   // Next raster position and the events that position change produces.
   always_comb begin
      tick      = bus.enable && (div == DIV_LAST);
      x_nxt     = bus.x;
      y_nxt     = bus.y;
      line_evt  = tick && (bus.x == X_LAST);
      frame_evt = line_evt && (bus.y == Y_LAST);
      if (tick) begin
         if (bus.x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (bus.y == Y_LAST) ? '0 : bus.y + 10'd1;
         end else begin
            x_nxt = bus.x + 10'd1;
         end
      end
      req_rise = line_evt && (y_nxt == Y_REQ);
      deadline = line_evt && (y_nxt == Y_ACT_FIRST);
   end

   // Handshake next state: ack has priority over the deadline.
   always_comb begin
      state_nxt = state;
      ovr_set   = 1'b0;
      case (state)
         VB_IDLE: if (req_rise) state_nxt = VB_OPEN;
         VB_OPEN: begin
            if (bus.vblank_ack) begin
               state_nxt = VB_IDLE;
            end else if (deadline) begin
               state_nxt = VB_IDLE;
               ovr_set   = 1'b1;
            end
         end
         default: state_nxt = VB_IDLE;
      endcase
   end

   // Handshake state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= VB_IDLE;
      else        state <= state_nxt;
   end

   // Counters and registered outputs; decodes use the next position so they line up with x/y.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div             <= '0;
         bus.x           <= '0;
         bus.y           <= '0;
         bus.hsync       <= SYNC_POL;
         bus.vsync       <= SYNC_POL;
         bus.active      <= 1'b0;
         bus.pix_tick    <= 1'b0;
         bus.line_start  <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.frame_count <= '0;
         bus.vblank_req  <= 1'b0;
         bus.overrun     <= 1'b0;
      end else begin
         div             <= (!bus.enable || tick) ? 2'd0 : div + 2'd1;
         bus.x           <= x_nxt;
         bus.y           <= y_nxt;
         bus.hsync       <= (x_nxt < X_SYNC_END) ? SYNC_POL : ~SYNC_POL;
         bus.vsync       <= (y_nxt < Y_SYNC_END) ? SYNC_POL : ~SYNC_POL;
         bus.active      <= (x_nxt >= X_ACT_FIRST) && (x_nxt <= X_ACT_LAST) &&
                            (y_nxt >= Y_ACT_FIRST) && (y_nxt <= Y_ACT_LAST);
         bus.pix_tick    <= tick;
         bus.line_start  <= line_evt;
         bus.frame_start <= frame_evt;
         if (frame_evt) bus.frame_count <= bus.frame_count + 8'd1;
         bus.vblank_req  <= (state_nxt == VB_OPEN);
         if (ovr_set)              bus.overrun <= 1'b1;
         else if (bus.overrun_clr) bus.overrun <= 1'b0;
      end
   end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Master VGA timing sequencer for the display pipeline.
- Generates the raw horizontal and vertical counters (x, y) that feed the coordinate-calculation stage, plus hsync, vsync, active, line and frame strobes.
- Runs a vertical-blank update handshake that gives game/sprite logic a safe window to change frame state, and flags an overrun when that window is missed.
- Sits directly after the clock/reset and ahead of coordinate calculation and pixel generation.

Parameters:
- CLK_DIV, 1: system clocks per pixel tick; legal 1..4.
- H_SYNC, 96: hsync width in pixels.
- H_BP, 48: horizontal back porch.
- H_ACT, 640: horizontal active pixels.
- H_FP, 16: horizontal front porch.
- V_SYNC, 2: vsync width in lines.
- V_BP, 33: vertical back porch.
- V_ACT, 480: active lines.
- V_FP, 10: vertical front porch.
- SYNC_POL, 0: asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  timing run enable; low freezes all counters
- vblank_ack  in  1  update-done acknowledge from game logic
- overrun_clr  in  1  clears sticky overrun flag
- x  out  10  raw horizontal count, 0..H_TOTAL-1
- y  out  10  raw vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- active  out  1  x,y inside the visible region
- pix_tick  out  1  one-clk strobe when counters advance
- line_start  out  1  one-clk strobe when x wraps to 0
- frame_start  out  1  one-clk strobe when (x,y) wraps to (0,0)
- frame_count  out  8  frames completed, wraps 255->0
- vblank_req  out  1  update window open
- overrun  out  1  sticky: vblank window closed without ack

Behaviour:
- Reset: rst_n is synchronous, active-low; clk is the only clock.
  - During reset: x=0, y=0, divider=0, frame_count=0, vblank_req=0, overrun=0, all strobes 0, active=0.
  - hsync=vsync=SYNC_POL, i.e. both asserted, since (0,0) is in both sync regions.
  - Reset mid-frame aborts the frame immediately, with no frame_start pulse.
- Totals: H_TOTAL=H_SYNC+H_BP+H_ACT+H_FP (800); V_TOTAL likewise (525). Both must be ≤1024; elaboration error otherwise.
- Region order per line and per frame: sync, back porch, active, front porch.
  - Horizontal: hsync asserted for x<H_SYNC. Active x is [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] = 144..783.
  - Vertical: vsync asserted for y<V_SYNC. Active y is 35..514.
- Divider and pix_tick:
  - Divider counts 0..CLK_DIV-1; pix_tick=1 when divider==CLK_DIV-1 and enable=1.
  - With CLK_DIV=1, pix_tick=enable.
  - enable=0: divider forced to 0; x, y and all flags hold; no strobes.
- Counter advance on pix_tick:
  - x increments.
  - At x=H_TOTAL-1: x goes to 0 and y increments.
  - At y=V_TOTAL-1 and x=H_TOTAL-1: both go to 0 and frame_count increments.
- Output timing:
  - All outputs are registered.
  - hsync, vsync and active are decoded from the next counter values, so they are valid in the same cycle as the x,y they describe (zero relative latency).
- Strobes:
  - line_start and frame_start assert for exactly one clk, in the cycle in which the new x=0 (resp. x=0,y=0) first appears.
  - frame_start implies line_start.
- Vblank handshake:
  - vblank_req rises in the cycle x=0, y=H... first front-porch line, i.e. y=V_SYNC+V_BP+V_ACT (515).
  - It holds until vblank_ack is sampled high, then drops the next cycle. vblank_ack is ignored while vblank_req=0.
  - Deadline is the cycle (x,y) becomes (0, V_SYNC+V_BP), the first active line (35). If vblank_req is still 1 there, it drops and overrun sets.
  - If ack and deadline coincide, ack wins and there is no overrun.
  - overrun_clr clears overrun. If set and clear coincide, set wins.
  - enable=0 freezes the handshake state; ack is still accepted.

Test Plan:
- Reset then enable=1, CLK_DIV=1:
  - x counts 0..799 then wraps.
  - line_start is high exactly in cycles where x=0, first at clk 800.
  - hsync low for x 0..95.
  - active first high at (144,35), last at (783,514).
- Full frame:
  - frame_start period is exactly 420000 clks; frame_count increments 0->1->2.
  - Drive 256 frames and check frame_count wraps to 0.
  - vsync low only for y 0..1.
- CLK_DIV=2:
  - pix_tick every 2nd clk; x advances only on ticks.
  - Frame period is 840000 clks.
  - enable=0 for 10 clks at x=300: x stays 300, no tick; resume continues at 301.
- Vblank handshake with ack:
  - vblank_req rises at (0,515).
  - Ack 100 clks later: req drops next clk and overrun stays 0.
- No ack:
  - req drops at (0,35) of the next frame and overrun=1.
  - overrun_clr clears it.
  - Ack coinciding with the (0,35) cycle gives overrun=0.
  - Clear coinciding with a new overrun leaves overrun=1.
- Reset asserted at (400,200) with vblank_req=1:
  - Next clk: x=y=0, vblank_req=0, frame_count=0, hsync=vsync=0.
  - No frame_start pulse.
